jk_bank_sequencer: RTL and testbench
====================================

Name: jk_bank_sequencer

Overview:
Command-driven controller for a WIDTH-bit bank of JK flip-flops. Each command (load, clear, preset, toggle, increment, decrement) becomes per-bit J/K drive for exactly one clock. The bank's Q outputs are then read back and compared against the expected value. On mismatch the block issues corrective drive up to MAX_RETRY times before flagging an error. It sits between a command source (valid/ready handshake) and the flip-flop bank, which is instantiated outside this block.

Parameters:
WIDTH, 8, bit width of the JK bank, j_out, k_out, q_fb, cmd_data and result
MAX_RETRY, 3, maximum corrective drives after the first mismatch (0 = no retry)

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  high only in IDLE and when rst=0; a command is accepted on an edge where valid&&ready
cmd_op  input  3  000 NOP, 001 LOAD, 010 CLEAR, 011 PRESET, 100 TOGGLE, 101 INC, 110 DEC, 111 reserved
cmd_data  input  WIDTH  LOAD value, or TOGGLE mask; ignored by the other ops
q_fb  input  WIDTH  Q outputs of the JK bank
j_out  output  WIDTH  J drive to the bank (registered)
k_out  output  WIDTH  K drive to the bank (registered)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  valid only with done; 1 = reserved op or retries exhausted
result  output  WIDTH  expected value; held from the DONE cycle until the next accept

Behaviour:
- Reset, applied at any time including mid-command:
  - next state IDLE; j_out=0, k_out=0, done=0, err=0, busy=0, result=0, retry count=0.
  - No partial drive survives the reset edge.
- States: IDLE, DRIVE, CHECK, DONE.
- Accept edge (IDLE, valid&&ready):
  - Snapshot q_fb as S and compute expected value E:
    - LOAD: E=cmd_data
    - CLEAR: E=0
    - PRESET: E=all ones
    - TOGGLE: E=S^cmd_data
    - INC: E=S+1, mod 2^WIDTH
    - DEC: E=S-1, mod 2^WIDTH
  - For every op except NOP and reserved, go to DRIVE.
- J/K encoding in DRIVE:
  - LOAD, CLEAR, PRESET: J=E, K=~E.
  - TOGGLE: J=K=cmd_data.
  - INC: J[i]=K[i]=AND(S[i-1:0]); bit 0 is always 1.
  - DEC: J[i]=K[i]=AND(~S[i-1:0]); bit 0 is always 1.
  - Drive is registered, so j_out/k_out are valid for exactly the DRIVE cycle and are 0 in every other state.
  - The bank samples at the end-of-DRIVE edge.
- DRIVE -> CHECK unconditionally.
- CHECK (j_out=k_out=0), comparing q_fb against E:
  - q_fb==E: go to DONE with err=0.
  - Mismatch and retry count < MAX_RETRY: increment the count and go to DRIVE with corrective drive J=E&~q_fb, K=~E&q_fb. This correction is idempotent for every op.
  - Mismatch and retry count == MAX_RETRY: go to DONE with err=1.
- NOP: accept -> DONE directly; E=S, err=0, no drive.
- Reserved op: accept -> DONE directly; err=1, result=S, no drive.
- DONE (one cycle):
  - done=1, err valid, result=E, cmd_ready=0.
  - Next state IDLE; retry count cleared.
- Latency, clean command: accept at edge T; DRIVE during cycle T+1; CHECK during T+2; done high during T+3; cmd_ready high again during T+4.
  - Each retry adds 2 cycles.
  - NOP and reserved ops: done high during T+1.
- Wrap-around:
  - INC from all ones drives J=K=all ones, giving E=0.
  - DEC from 0 drives all ones, giving E=all ones.
- Handshake rules:
  - cmd_op and cmd_data are sampled only at the accept edge; later changes are ignored.
  - cmd_valid while busy is held off and never dropped or queued.
- q_fb is treated as synchronous to clk. The block makes no assumption about bank behaviour except during CHECK.

Test Plan:
- Reset, then LOAD 0xA5 with a bank model correct:
  - j_out=0xA5, k_out=0x5A for exactly one cycle.
  - done at accept+3 with err=0, result=0xA5, busy high for 3 cycles.
- Bank at 0xFF, INC:
  - j_out=k_out=0xFF.
  - result=0x00, err=0.
- Bank at 0x00, then DEC then TOGGLE mask 0x0F, back-to-back with cmd_valid held high:
  - Results 0xFF then 0xF0.
  - Second accept happens exactly at the cycle after the first done; no command is lost.
- Bank model with bit 3 stuck-at-0, LOAD 0x08, MAX_RETRY=3:
  - Three corrective drives with j_out=0x08, k_out=0x00.
  - done at accept+9 with err=1.
- Bank model that fails only the first sample, PRESET:
  - One retry, then done at accept+5 with err=0, result=0xFF.
- cmd_op=111:
  - done at accept+1, err=1, j_out/k_out never nonzero.
- rst asserted during DRIVE of a LOAD:
  - Next cycle j_out=k_out=0, busy=0, cmd_ready=1.
  - No done pulse.

Source files
------------

// File: rtl/jk_bank_sequencer.sv
// Turns valid/ready commands into one-cycle J/K drive for an external JK bank, then verifies and corrects it.
// Latency: accept->done 3 cycles (+2 per retry, 1 for NOP/reserved); cmd_valid is held off while busy.
module jk_bank_sequencer #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int RW = $clog2(MAX_RETRY + 2);

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_CLEAR  = 3'b010;
  localparam logic [2:0] OP_PRESET = 3'b011;
  localparam logic [2:0] OP_TOGGLE = 3'b100;
  localparam logic [2:0] OP_INC    = 3'b101;
  localparam logic [2:0] OP_DEC    = 3'b110;

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_CHECK, ST_DONE} state_t;

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_exp, w_exp;
  logic [WIDTH-1:0] r_j, w_j;
  logic [WIDTH-1:0] r_k, w_k;
  logic [RW-1:0]    r_retry, w_retry;
  logic             r_err, w_err;
  logic [WIDTH-1:0] r_result, w_result;
  logic [WIDTH-1:0] w_inc_mask;
  logic [WIDTH-1:0] w_dec_mask;

  // Bit i toggles on INC when all lower bits are 1, on DEC when all lower bits are 0.
  assign w_inc_mask[0] = 1'b1;
  assign w_dec_mask[0] = 1'b1;
  for (genvar g = 1; g < WIDTH; g++) begin : g_carry
    assign w_inc_mask[g] = &q_fb[g-1:0];
    assign w_dec_mask[g] = ~|q_fb[g-1:0];
  end

  always_comb begin
    w_state  = r_state;
    w_exp    = r_exp;
    w_j      = '0;
    w_k      = '0;
    w_retry  = r_retry;
    w_err    = r_err;
    w_result = r_result;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_retry = '0;
          w_err   = 1'b0;
          w_state = ST_DRIVE;
          case (cmd_op)
            OP_LOAD:   begin w_exp = cmd_data;       w_j = cmd_data;   w_k = ~cmd_data;  end
            OP_CLEAR:  begin w_exp = '0;             w_j = '0;         w_k = '1;         end
            OP_PRESET: begin w_exp = '1;             w_j = '1;         w_k = '0;         end
            OP_TOGGLE: begin w_exp = q_fb ^ cmd_data; w_j = cmd_data;  w_k = cmd_data;   end
            OP_INC:    begin w_exp = q_fb + 1'b1;    w_j = w_inc_mask; w_k = w_inc_mask; end
            OP_DEC:    begin w_exp = q_fb - 1'b1;    w_j = w_dec_mask; w_k = w_dec_mask; end
            default: begin
              // NOP and reserved skip the bank entirely; reserved reports an error.
              w_exp    = q_fb;
              w_result = q_fb;
              w_err    = (cmd_op != OP_NOP);
              w_state  = ST_DONE;
            end
          endcase
        end
      end
      ST_DRIVE: w_state = ST_CHECK;
      ST_CHECK: begin
        if (q_fb == r_exp) begin
          w_state  = ST_DONE;
          w_err    = 1'b0;
          w_result = r_exp;
        end else if (r_retry < RW'(MAX_RETRY)) begin
          w_retry = r_retry + RW'(1);
          w_j     = r_exp & ~q_fb;
          w_k     = ~r_exp & q_fb;
          w_state = ST_DRIVE;
        end else begin
          w_state  = ST_DONE;
          w_err    = 1'b1;
          w_result = r_exp;
        end
      end
      ST_DONE: begin
        w_state = ST_IDLE;
        w_retry = '0;
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_exp    <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_retry  <= '0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state;
      r_exp    <= w_exp;
      r_j      <= w_j;
      r_k      <= w_k;
      r_retry  <= w_retry;
      r_err    <= w_err;
      r_result <= w_result;
    end
  end

  assign cmd_ready = (r_state == ST_IDLE) && !rst;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign err       = done && r_err;
  assign result    = r_result;
  assign j_out     = r_j;
  assign k_out     = r_k;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer with a behavioural JK bank that can hold a stuck bit or miss one sample.
module tb_jk_bank_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'b000;
  logic [7:0] cmd_data = 8'h00;
  logic [7:0] q_fb;
  logic [7:0] j_out, k_out;
  logic       busy, done, err;
  logic [7:0] result;

  jk_bank_sequencer #(.WIDTH(8), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .q_fb(q_fb),
    .j_out(j_out), .k_out(k_out), .busy(busy), .done(done), .err(err), .result(result)
  );

  always #5 clk = ~clk;

  // JK bank: Q+ = J&~Q | ~K&Q, with optional stuck-at-0 bits and skipped samples.
  logic [7:0] bank = 8'h00;
  logic [7:0] stuck = 8'h00;
  int         skip_req = 0;
  int         skip_done = 0;
  assign q_fb = bank;
  always @(posedge clk) begin
    if ((j_out | k_out) != 8'h00 && skip_req != skip_done) skip_done <= skip_done + 1;
    else bank <= ((j_out & ~bank) | (~k_out & bank)) & ~stuck;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int         lat, n_drv, busy_cnt, acc_wait;
  logic [7:0] fj, fk, lj, lk, d_res;
  logic       d_err, got_done;

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] data, input bit hold);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; acc_wait = 0;
    while (!cmd_ready && acc_wait < 20) begin @(negedge clk); acc_wait++; end
    if (!cmd_ready) begin
      chk_eq("accept_timeout", 32'(cmd_ready), 32'(1));
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!hold) begin cmd_valid = 1'b0; cmd_op = 3'b111; cmd_data = ~data; end
    lat = 1; n_drv = 0; busy_cnt = 0; got_done = 1'b0;
    fj = 8'h00; fk = 8'h00; lj = 8'h00; lk = 8'h00; d_res = 8'h00; d_err = 1'b0;
    while (lat <= 40) begin
      if (busy) busy_cnt++;
      if (j_out != 8'h00 || k_out != 8'h00) begin
        if (n_drv == 0) begin fj = j_out; fk = k_out; end
        lj = j_out; lk = k_out; n_drv++;
      end
      if (done) begin got_done = 1'b1; d_err = err; d_res = result; break; end
      @(negedge clk); lat++;
    end
    if (!got_done) chk_eq("done_timeout", 32'(done), 32'(1));
  endtask

  initial begin
    int n_done;
    repeat (3) @(negedge clk);
    chk_eq("rst_j", 32'(j_out), 32'(0));
    chk_eq("rst_k", 32'(k_out), 32'(0));
    chk_eq("rst_busy", 32'(busy), 32'(0));
    chk_eq("rst_done", 32'(done), 32'(0));
    chk_eq("rst_result", 32'(result), 32'(0));
    chk_eq("rst_ready_low", 32'(cmd_ready), 32'(0));
    rst = 1'b0;
    #1;
    chk_eq("ready_after_rst", 32'(cmd_ready), 32'(1));

    do_cmd(3'b001, 8'hA5, 1'b0);
    chk_eq("load_lat", 32'(lat), 32'(3));
    chk_eq("load_j", 32'(fj), 32'hA5);
    chk_eq("load_k", 32'(fk), 32'h5A);
    chk_eq("load_ndrv", 32'(n_drv), 32'(1));
    chk_eq("load_busy", 32'(busy_cnt), 32'(3));
    chk_eq("load_err", 32'(d_err), 32'(0));
    chk_eq("load_res", 32'(d_res), 32'hA5);
    @(negedge clk);
    chk_eq("hold_res", 32'(result), 32'hA5);
    chk_eq("hold_done", 32'(done), 32'(0));
    chk_eq("hold_ready", 32'(cmd_ready), 32'(1));

    do_cmd(3'b001, 8'hFF, 1'b0);
    do_cmd(3'b101, 8'h00, 1'b0);
    chk_eq("inc_j", 32'(fj), 32'hFF);
    chk_eq("inc_k", 32'(fk), 32'hFF);
    chk_eq("inc_res", 32'(d_res), 32'h00);
    chk_eq("inc_err", 32'(d_err), 32'(0));
    chk_eq("inc_lat", 32'(lat), 32'(3));

    do_cmd(3'b010, 8'h00, 1'b0);
    chk_eq("clear_res", 32'(d_res), 32'h00);
    do_cmd(3'b110, 8'h00, 1'b1);
    chk_eq("dec_j", 32'(fj), 32'hFF);
    chk_eq("dec_res", 32'(d_res), 32'hFF);
    cmd_op = 3'b100; cmd_data = 8'h0F;
    @(negedge clk);
    chk_eq("b2b_ready", 32'(cmd_ready), 32'(1));
    do_cmd(3'b100, 8'h0F, 1'b0);
    chk_eq("b2b_wait", 32'(acc_wait), 32'(0));
    chk_eq("tog_j", 32'(fj), 32'h0F);
    chk_eq("tog_k", 32'(fk), 32'h0F);
    chk_eq("tog_res", 32'(d_res), 32'hF0);

    stuck = 8'h08;
    do_cmd(3'b001, 8'h08, 1'b0);
    chk_eq("stuck_lat", 32'(lat), 32'(9));
    chk_eq("stuck_err", 32'(d_err), 32'(1));
    chk_eq("stuck_ndrv", 32'(n_drv), 32'(4));
    chk_eq("stuck_corr_j", 32'(lj), 32'h08);
    chk_eq("stuck_corr_k", 32'(lk), 32'h00);
    chk_eq("stuck_res", 32'(d_res), 32'h08);
    stuck = 8'h00;

    skip_req = skip_req + 1;
    do_cmd(3'b011, 8'h00, 1'b0);
    chk_eq("retry_lat", 32'(lat), 32'(5));
    chk_eq("retry_err", 32'(d_err), 32'(0));
    chk_eq("retry_ndrv", 32'(n_drv), 32'(2));
    chk_eq("retry_res", 32'(d_res), 32'hFF);

    do_cmd(3'b111, 8'h55, 1'b0);
    chk_eq("rsv_lat", 32'(lat), 32'(1));
    chk_eq("rsv_err", 32'(d_err), 32'(1));
    chk_eq("rsv_ndrv", 32'(n_drv), 32'(0));
    chk_eq("rsv_res", 32'(d_res), 32'hFF);

    do_cmd(3'b000, 8'h00, 1'b0);
    chk_eq("nop_lat", 32'(lat), 32'(1));
    chk_eq("nop_err", 32'(d_err), 32'(0));
    chk_eq("nop_res", 32'(d_res), 32'hFF);

    cmd_valid = 1'b1; cmd_op = 3'b001; cmd_data = 8'h3C; acc_wait = 0;
    while (!cmd_ready && acc_wait < 20) begin @(negedge clk); acc_wait++; end
    chk_eq("mid_accept", 32'(cmd_ready), 32'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
    chk_eq("mid_drive_j", 32'(j_out), 32'h3C);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_eq("mid_rst_j", 32'(j_out), 32'(0));
    chk_eq("mid_rst_k", 32'(k_out), 32'(0));
    chk_eq("mid_rst_busy", 32'(busy), 32'(0));
    chk_eq("mid_rst_ready", 32'(cmd_ready), 32'(1));
    chk_eq("mid_rst_res", 32'(result), 32'(0));
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk_eq("mid_rst_nodone", 32'(n_done), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
